// File: rtl/gtest_objection_pkg.sv
// Shared types for the objection controller: FSM states, report severities
// and a saturating 16-bit increment used by the report counters.
package gtest_objection_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEV_INFO  = 2'd0,
    SEV_WARN  = 2'd1,
    SEV_ERROR = 2'd2,
    SEV_FATAL = 2'd3
  } sev_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gtest_popcount.sv
// Combinational population count of a W-bit vector.
module gtest_popcount #(
  parameter int W = 4
) (
  input  logic [W-1:0]               vec,
  output logic [$clog2(W+1)-1:0]     count
);
  localparam int CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/gtest_objection_ctrl.sv
// Test-run objection controller: counts raised/dropped objections, drains, and
// reports a registered pass/fail verdict. Watchdog enabled by GTEST_OBJ_TIMEOUT_EN.
module gtest_objection_ctrl
  import gtest_objection_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int CNT_W          = 8,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [N_SRC-1:0] raise,
  input  logic [N_SRC-1:0] drop,
  input  logic             rpt_valid,
  input  logic [1:0]       rpt_sev,
  output logic             rpt_ready,
  output logic [CNT_W-1:0] objections,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      num_warn,
  output logic [15:0]      num_err,
  output logic             fatal_seen,
  output logic             underflow,
  output logic             timeout
);
  localparam int PC_W    = $clog2(N_SRC + 1);
  localparam int SUM_W   = CNT_W + PC_W + 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc_raise, pc_drop;
  logic [CNT_W-1:0]   count_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic [15:0]        warn_nxt, err_nxt;
  logic               fatal_nxt, underflow_nxt, timeout_nxt;
  logic               raised, raised_nxt;
  logic               active, rpt_fire, fatal_hit;
  logic signed [SUM_W-1:0] net;

`ifdef GTEST_OBJ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt, wd_nxt;
`else
  // The watchdog limit has no consumer when the watchdog is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  gtest_popcount #(.W(N_SRC)) u_pc_raise (.vec(raise), .count(pc_raise));
  gtest_popcount #(.W(N_SRC)) u_pc_drop  (.vec(drop),  .count(pc_drop));

  assign active    = (state == ST_RUN) || (state == ST_DRAIN);
  assign rpt_fire  = rpt_valid && rpt_ready;
  assign fatal_hit = rpt_fire && (sev_t'(rpt_sev) == SEV_FATAL);
  // Signed, wide enough that neither saturation nor underflow can wrap.
  assign net = $signed(SUM_W'(objections)) + $signed(SUM_W'(pc_raise))
             - $signed(SUM_W'(pc_drop));

  always_comb begin
    // NOTE: every variable is given a default first so no path infers a latch.
    state_nxt     = state;
    count_nxt     = objections;
    drain_nxt     = drain_cnt;
    warn_nxt      = num_warn;
    err_nxt       = num_err;
    fatal_nxt     = fatal_seen;
    underflow_nxt = underflow;
    timeout_nxt   = timeout;
    raised_nxt    = raised;
`ifdef GTEST_OBJ_TIMEOUT_EN
    wd_nxt        = wd_cnt;
`endif
    if (!active) begin
      if (start) begin
        state_nxt     = ST_RUN;
        count_nxt     = '0;
        drain_nxt     = '0;
        warn_nxt      = '0;
        err_nxt       = '0;
        fatal_nxt     = 1'b0;
        underflow_nxt = 1'b0;
        timeout_nxt   = 1'b0;
        raised_nxt    = 1'b0;
`ifdef GTEST_OBJ_TIMEOUT_EN
        wd_nxt        = '0;
`endif
      end
    end else begin
      if (net[SUM_W-1]) begin
        count_nxt     = '0;
        underflow_nxt = 1'b1;
      end else if (net > $signed(SUM_W'({CNT_W{1'b1}}))) begin
        count_nxt = '1;
      end else begin
        count_nxt = net[CNT_W-1:0];
      end
      if (|raise) raised_nxt = 1'b1;

      if (rpt_fire) begin
        case (sev_t'(rpt_sev))
          SEV_WARN:  warn_nxt  = sat_inc16(num_warn);
          SEV_ERROR: err_nxt   = sat_inc16(num_err);
          SEV_FATAL: fatal_nxt = 1'b1;
          default:   ;
        endcase
      end

      // Drain counts quiet cycles after the edge that brought the count to zero.
      if (state == ST_RUN) begin
        if (count_nxt == '0) begin
          state_nxt = ST_DRAIN;
          drain_nxt = '0;
        end
      end else if (count_nxt != '0) begin
        state_nxt = ST_RUN;
      end else begin
        drain_nxt = drain_cnt + DRAIN_W'(1);
        if (drain_nxt == DRAIN_W'(DRAIN_CYCLES)) state_nxt = ST_DONE;
      end

`ifdef GTEST_OBJ_TIMEOUT_EN
      if (count_nxt != objections) begin
        wd_nxt = '0;
      end else begin
        wd_nxt = wd_cnt + WD_W'(1);
        if (wd_nxt == WD_W'(TIMEOUT_CYCLES)) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_DONE;
        end
      end
`endif

      if (fatal_hit) state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      objections <= '0;
      drain_cnt  <= '0;
      num_warn   <= '0;
      num_err    <= '0;
      fatal_seen <= 1'b0;
      underflow  <= 1'b0;
      raised     <= 1'b0;
      busy       <= 1'b0;
      rpt_ready  <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
`ifdef GTEST_OBJ_TIMEOUT_EN
      timeout    <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_nxt;
      objections <= count_nxt;
      drain_cnt  <= drain_nxt;
      num_warn   <= warn_nxt;
      num_err    <= err_nxt;
      fatal_seen <= fatal_nxt;
      underflow  <= underflow_nxt;
      raised     <= raised_nxt;
      busy       <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      rpt_ready  <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      done       <= (state_nxt == ST_DONE);
      pass       <= (state_nxt == ST_DONE) && (err_nxt == 16'd0) && !fatal_nxt
                    && !underflow_nxt && !timeout_nxt && raised_nxt;
`ifdef GTEST_OBJ_TIMEOUT_EN
      timeout    <= timeout_nxt;
      wd_cnt     <= wd_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_gtest_objection_ctrl.sv
// Directed bench for gtest_objection_ctrl: inputs are driven and outputs
// sampled 1 time unit after each rising clock edge.
module tb_gtest_objection_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  raise, drop;
  logic        rpt_valid;
  logic [1:0]  rpt_sev;
  logic        rpt_ready;
  logic [7:0]  objections;
  logic        busy, done, pass;
  logic [15:0] num_warn, num_err;
  logic        fatal_seen, underflow, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gtest_objection_ctrl #(
    .N_SRC(4), .CNT_W(8), .DRAIN_CYCLES(16), .TIMEOUT_CYCLES(65535)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .raise(raise), .drop(drop),
    .rpt_valid(rpt_valid), .rpt_sev(rpt_sev), .rpt_ready(rpt_ready),
    .objections(objections), .busy(busy), .done(done), .pass(pass),
    .num_warn(num_warn), .num_err(num_err), .fatal_seen(fatal_seen),
    .underflow(underflow), .timeout(timeout)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_wait: done=%b after %0d cycles, required 1", tag, done, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; raise = '0; drop = '0; rpt_valid = 1'b0; rpt_sev = '0;
    step(); step();
    checks++;
    if ({objections, busy, done, pass, rpt_ready, num_warn, num_err,
         fatal_seen, underflow, timeout} !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs: obj=%0d busy=%b done=%b pass=%b rdy=%b warn=%0d err=%0d fatal=%b uf=%b to=%b, required all 0",
               objections, busy, done, pass, rpt_ready, num_warn, num_err, fatal_seen, underflow, timeout);
    end
    reset_n = 1'b1;
    step();
    raise = 4'b1111;
    step();
    raise = '0;
    checks++;
    if ({busy, rpt_ready, objections} !== 10'd0) begin
      errors++;
      $display("FAIL idle_ignores_raise: busy=%b rdy=%b obj=%0d, required 0 0 0", busy, rpt_ready, objections);
    end
  endtask

  task automatic test_basic_run();
    start_run();
    checks++;
    if ({busy, rpt_ready, done, objections} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL start_enters_run: busy=%b rdy=%b done=%b obj=%0d, required 1 1 0 0", busy, rpt_ready, done, objections);
    end
    raise = 4'b0001; step(); raise = '0;
    checks++;
    if (objections !== 8'd1) begin
      errors++;
      $display("FAIL basic_raise: obj=%0d, required 1", objections);
    end
    repeat (5) step();
    checks++;
    if (objections !== 8'd1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: obj=%0d busy=%b done=%b, required 1 1 0", objections, busy, done);
    end
    drop = 4'b0001; step(); drop = '0;
    checks++;
    if (objections !== 8'd0) begin
      errors++;
      $display("FAIL basic_drop: obj=%0d, required 0", objections);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (done !== (k == 16)) begin
        errors++;
        $display("FAIL basic_drain_cycle%0d: done=%b, required %b", k, done, (k == 16));
      end
    end
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0 || rpt_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_verdict: pass=%b busy=%b rdy=%b, required 1 0 0", pass, busy, rpt_ready);
    end
  endtask

  task automatic test_count_math();
    start_run();
    raise = 4'b1111; step(); raise = '0;
    checks++;
    if (objections !== 8'd4) begin
      errors++;
      $display("FAIL count_raise4: obj=%0d, required 4", objections);
    end
    raise = 4'b0100; drop = 4'b0011; step(); raise = '0; drop = '0;
    checks++;
    if (objections !== 8'd3) begin
      errors++;
      $display("FAIL count_mixed: obj=%0d, required 3", objections);
    end
    raise = 4'b1000; drop = 4'b1000; step(); raise = '0; drop = '0;
    checks++;
    if (objections !== 8'd3) begin
      errors++;
      $display("FAIL count_same_src_nets_zero: obj=%0d, required 3", objections);
    end
    raise = 4'b1111; repeat (64) step(); raise = '0;
    checks++;
    if (objections !== 8'd255) begin
      errors++;
      $display("FAIL count_saturate: obj=%0d, required 255", objections);
    end
    drop = 4'b1111; repeat (63) step(); drop = '0;
    checks++;
    if (objections !== 8'd3 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL count_drain_down: obj=%0d uf=%b, required 3 0", objections, underflow);
    end
    drop = 4'b0111; step(); drop = '0;
    checks++;
    if (objections !== 8'd0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL count_exact_zero: obj=%0d uf=%b, required 0 0", objections, underflow);
    end
    wait_done("count", 20);
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL count_pass: pass=%b, required 1", pass);
    end
  endtask

  task automatic test_underflow();
    start_run();
    raise = 4'b0001; step(); raise = '0;
    drop  = 4'b0001; step();
    checks++;
    if (objections !== 8'd0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_first_drop: obj=%0d uf=%b, required 0 0", objections, underflow);
    end
    step(); drop = '0;
    checks++;
    if (objections !== 8'd0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_extra_drop: obj=%0d uf=%b, required 0 1", objections, underflow);
    end
    wait_done("underflow", 20);
    checks++;
    if (pass !== 1'b0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_verdict: pass=%b uf=%b, required 0 1", pass, underflow);
    end
  endtask

  task automatic test_drain_abort();
    start_run();
    raise = 4'b0100; step(); raise = '0;
    drop  = 4'b0100; step(); drop = '0;
    repeat (9) step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_mid_drain: done=%b busy=%b, required 0 1", done, busy);
    end
    raise = 4'b0100; step(); raise = '0;
    checks++;
    if (objections !== 8'd1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_reraise: obj=%0d busy=%b done=%b, required 1 1 0", objections, busy, done);
    end
    repeat (20) step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_stays_run: done=%b busy=%b, required 0 1", done, busy);
    end
    drop = 4'b0100; step(); drop = '0;
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (done !== (k == 16)) begin
        errors++;
        $display("FAIL abort_drain_cycle%0d: done=%b, required %b", k, done, (k == 16));
      end
    end
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL abort_pass: pass=%b, required 1", pass);
    end
  endtask

  task automatic test_reports();
    start_run();
    raise = 4'b0001; step(); raise = '0;
    rpt_valid = 1'b1;
    rpt_sev = 2'd1; step();
    rpt_sev = 2'd0; step();
    rpt_sev = 2'd2; repeat (3) step();
    rpt_valid = 1'b0;
    checks++;
    if (num_warn !== 16'd1 || num_err !== 16'd3 || fatal_seen !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rpt_counts: warn=%0d err=%0d fatal=%b done=%b, required 1 3 0 0",
               num_warn, num_err, fatal_seen, done);
    end
    rpt_valid = 1'b1; rpt_sev = 2'd3; step(); rpt_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || fatal_seen !== 1'b1 || pass !== 1'b0 || num_err !== 16'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rpt_fatal: done=%b fatal=%b pass=%b err=%0d busy=%b, required 1 1 0 3 0",
               done, fatal_seen, pass, num_err, busy);
    end
    rpt_valid = 1'b1; rpt_sev = 2'd2; step(); rpt_valid = 1'b0;
    checks++;
    if (num_err !== 16'd3 || rpt_ready !== 1'b0) begin
      errors++;
      $display("FAIL rpt_done_ignored: err=%0d rdy=%b, required 3 0", num_err, rpt_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    start_run();
    checks++;
    if (num_err !== 16'd0 || num_warn !== 16'd0 || fatal_seen !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clears: err=%0d warn=%0d fatal=%b busy=%b, required 0 0 0 1",
               num_err, num_warn, fatal_seen, busy);
    end
    raise = 4'b0011; step(); raise = '0;
    checks++;
    if (objections !== 8'd2) begin
      errors++;
      $display("FAIL midrun_count: obj=%0d, required 2", objections);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({objections, busy, done, pass, rpt_ready, num_warn, num_err,
         fatal_seen, underflow, timeout} !== 47'd0) begin
      errors++;
      $display("FAIL async_reset: obj=%0d busy=%b done=%b pass=%b rdy=%b, required all 0",
               objections, busy, done, pass, rpt_ready);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if ({busy, rpt_ready, done} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b rdy=%b done=%b, required 0 0 0", busy, rpt_ready, done);
    end
    raise = 4'b0001; step(); raise = '0;
    checks++;
    if (objections !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_ignores_raise: obj=%0d, required 0", objections);
    end
    start_run();
    checks++;
    if (busy !== 1'b1 || rpt_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_start: busy=%b rdy=%b, required 1 1", busy, rpt_ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: bench still running at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_basic_run();
    test_count_math();
    test_underflow();
    test_drain_abort();
    test_reports();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gtest_objection_ctrl.md
GTEST_OBJECTION_CTRL -- requirements
Module: gtest_objection_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of objection sources.
REQ-002 SHALL have parameter CNT_W, default 8: objection counter width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 16: quiet cycles at zero objections before done.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit, used only under GTEST_OBJ_TIMEOUT_EN.
REQ-005 SHALL have port clock  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port start  in  1  single-cycle pulse that begins a run.
REQ-008 SHALL have port raise  in  N_SRC  per-source raise-objection pulses.
REQ-009 SHALL have port drop  in  N_SRC  per-source drop-objection pulses.
REQ-010 SHALL have port rpt_valid  in  1  report valid.
REQ-011 SHALL have port rpt_sev  in  2  severity: 0 INFO, 1 WARN, 2 ERROR, 3 FATAL.
REQ-012 SHALL have port rpt_ready  out  1  report accepted when rpt_valid and rpt_ready are both high.
REQ-013 SHALL have port objections  out  CNT_W  current outstanding objection count.
REQ-014 SHALL have port busy  out  1  high in RUN or DRAIN.
REQ-015 SHALL have port done  out  1  high in DONE.
REQ-016 SHALL have port pass  out  1  valid only while done is high.
REQ-017 SHALL have ports num_warn, num_err  out  16 each  accepted WARN and ERROR report counts.
REQ-018 SHALL have port fatal_seen  out  1  sticky flag for an accepted FATAL report.
REQ-019 SHALL have port underflow  out  1  sticky flag for a drop that would have taken the count below zero.
REQ-020 SHALL have port timeout  out  1  sticky flag for a watchdog expiry.

Function
REQ-021 SHALL implement FSM IDLE->RUN on start; RUN->DRAIN when objections==0; DRAIN->RUN when objections!=0; DRAIN->DONE when drain count reaches DRAIN_CYCLES; DONE->RUN on start.
REQ-022 SHALL, on start from IDLE or DONE, clear objections, counters and all sticky flags in the same edge that enters RUN.
REQ-023 SHALL ignore raise and drop outside RUN and DRAIN.
REQ-024 SHALL update the count each cycle as next = objections + popcount(raise) - popcount(drop); a raise and drop from the same source in one cycle nets zero.
REQ-025 SHALL clamp the count at 0 and set underflow when the net result is negative.
REQ-026 SHALL saturate the count at 2^CNT_W-1.
REQ-027 SHALL restart the drain counter at 0 on every DRAIN entry; any nonzero count in DRAIN returns the FSM to RUN on the next edge.
REQ-028 SHALL drive rpt_ready=1 in RUN and DRAIN and 0 in IDLE and DONE.
REQ-029 SHALL increment num_warn or num_err by 1 per accepted WARN or ERROR report, saturating at 16'hFFFF; INFO reports are accepted and not counted.
REQ-030 SHALL, on an accepted FATAL, set fatal_seen and enter DONE on the next edge, overriding all other transitions.
REQ-031 SHALL drive pass = (num_err==0) and not fatal_seen and not underflow and not timeout and at least one raise accepted during the run.
REQ-032 SHALL register all outputs, so an output reflects an input one cycle after the edge that samples it.

Reset
REQ-033 SHALL, while reset_n is low, force state IDLE, objections 0, busy 0, done 0, pass 0, rpt_ready 0, all counters 0 and all sticky flags 0.
REQ-034 SHALL abandon any run in progress on reset assertion mid-run, with no done pulse.

Configuration
REQ-035 SHALL, with GTEST_OBJ_TIMEOUT_EN defined, count RUN/DRAIN cycles since the last count change; on reaching TIMEOUT_CYCLES it SHALL set timeout and enter DONE.
REQ-036 SHALL, without GTEST_OBJ_TIMEOUT_EN, omit the watchdog logic and tie timeout to 0.

Structure
REQ-037 SHALL place the state enum (IDLE, RUN, DRAIN, DONE) and the severity enum in package gtest_objection_pkg.
REQ-038 SHALL implement popcount as sub-module gtest_popcount, parameterised on width and instantiated twice.

Verification
REQ-039 SHALL cover: start; raise[0]; 5 idle cycles; drop[0] -> objections 1 then 0, done exactly 16 cycles after the drop, pass=1.
REQ-040 SHALL cover: raise=4'b1111, then drop=4'b0011 with raise=4'b0100 in one cycle -> objections 4 then 3.
REQ-041 SHALL cover: a drop at count 0 -> underflow=1, objections stays 0, pass=0 at done.
REQ-042 SHALL cover: in DRAIN at cycle 10, raise[2] -> FSM returns to RUN and done stays 0; after a later drop[2], done follows 16 cycles later.
REQ-043 SHALL cover: 3 accepted ERROR reports then 1 FATAL -> num_err=3, fatal_seen=1, done next cycle, pass=0.
REQ-044 SHALL cover: reset_n low mid-RUN with count 2 -> all outputs zero asynchronously; after release, state IDLE and rpt_ready=0.
